wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Write-side front end for the 4-read/4-write register file.
- The register file commits at most one write per clock, chosen by fixed priority 0>1>2>3. Lower-priority simultaneous writes are silently lost.
- This block accepts writeback results from up to four execution units over valid/ready handshakes, buffers each in a per-port FIFO, and round-robin arbitrates them.
- It drives exactly one write per cycle into register-file write port 0. Register-file write ports 1-3 are tied off (enable=0).

Parameters:
- NUM_SRC, 4, number of producer ports (fixed at 4 for this revision)
- FIFO_DEPTH, 2, entries per producer FIFO; power of two, >=2
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- srcValid[3:0]  in  4  per-port result valid
- srcReady[3:0]  out  4  per-port ready; high when that port's FIFO is not full
- srcAddr0..srcAddr3  in  ADDR_W each  destination register
- srcData0..srcData3  in  DATA_W each  result data
- wbEnable  out  1  to regFile writeEnable0
- wbAddr  out  ADDR_W  to regFile write0
- wbData  out  DATA_W  to regFile dataIn0
- busy  out  1  any FIFO non-empty or wbEnable high

Behaviour:
- Reset (rst=1 at posedge):
  - all FIFOs empty; round-robin pointer = 0.
  - wbEnable=0, wbAddr=0, wbData=0, busy=0.
  - srcReady is combinational from FIFO full, so it reads 4'b1111 the cycle after reset.
  - Reset mid-operation discards all queued entries, with no write issued.
- Accept: port i transfers on a posedge where srcValid[i]&&srcReady[i].
  - If srcAddr==0, the transfer is accepted and dropped; nothing is enqueued and nothing is written.
  - Otherwise {addr,data} is pushed into FIFO i.
- srcReady[i] = !full[i]. It does not depend on srcValid (no combinational loop).
- Push and pop on a full FIFO in the same cycle: not allowed. Ready is low when full, and a pop frees the slot only for the next cycle.
- Arbitration, each cycle:
  - Candidate set = non-empty FIFOs.
  - Grant the first non-empty port scanning rrPtr, rrPtr+1, ... mod 4.
  - On grant g: pop FIFO g, register wbEnable=1, wbAddr/wbData = head of FIFO g, and set rrPtr=(g+1) mod 4.
  - No candidates: wbEnable=0, wbAddr/wbData hold their previous values, rrPtr unchanged.
- Latency:
  - Accepted at edge N, presented on wb* after edge N+1, committed in the regfile at edge N+2.
  - Minimum 2 cycles input-to-commit.
- Throughput: one write per cycle sustained. With all four ports streaming, each port gets 1/4 of the bandwidth. Starvation bound is 3 cycles.
- Ordering:
  - Per-port FIFO order is preserved.
  - No ordering is guaranteed between ports. Producers must not have two in-flight writes to the same register from different ports.
- Pointers: FIFO read/write pointers are log2(FIFO_DEPTH)+1 bits wide. Full/empty is decided by MSB comparison. Wrap-around is natural modulo.
- busy drops to 0 the cycle after the last write is presented.

Optional Feature:
- Macro: WB_PENDING_MASK_EN
- With the macro defined:
  - Adds output pendingMask [31:0]; bit r is high while any FIFO holds an entry with addr r, or wbEnable&&wbAddr==r.
  - Combinational from FIFO contents and output registers.
  - Bit 0 is always 0.
  - Used by the issue stage for hazard stalls.
- Without the macro: the port is absent, and the logic and FIFO-content comparators are not synthesized.

Decomposition:
- Shared package wb_pkg:
  - NUM_SRC, ADDR_W, DATA_W constants.
  - wb_entry_t struct {addr, data}.
  - REG_ZERO constant.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push, pop, full, empty, head output and, under WB_PENDING_MASK_EN, an entries array output. Instantiated NUM_SRC times.
- Arbiter, rrPtr and output registers stay in wb_arbiter.

Test Plan:
1. Reset, then srcValid=4'b0001, srcAddr0=5, srcData0=0xDEADBEEF for 1 cycle -> wbEnable=1, wbAddr=5, wbData=0xDEADBEEF exactly 1 cycle later; regfile read of r5 returns 0xDEADBEEF.
2. All four ports valid in one cycle (addr 1..4, data 0x11..0x44), rrPtr=0 -> writes issued on 4 consecutive cycles in order r1,r2,r3,r4; then wbEnable=0 and busy=0.
3. Port 2 streams continuously at addr 7 while ports 0 and 3 hold valid -> grants rotate 0,2,3,0,2,3…; no port waits more than 3 cycles.
4. srcValid1 with srcAddr1=0, data 0xFFFFFFFF -> srcReady1 stays 1, no wbEnable pulse, busy stays 0.
5. Port 0 sends 3 back-to-back beats while ports 1-3 saturate (FIFO_DEPTH=2) -> srcReady0 deasserts when full; all 3 beats are written in order with no loss.
6. Assert rst with 5 entries queued -> next cycle wbEnable=0 and busy=0, and no queued write ever reaches the regfile. With WB_PENDING_MASK_EN: pendingMask=0 after reset and shows bit 5 during scenario 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its per-port FIFOs.
package wb_pkg;

  localparam int NUM_SRC = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  // Register 0 is hard-wired; writes to it are dropped at the input.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries, one instance per producer port.
// Optional macro WB_PENDING_MASK_EN exposes the storage and per-slot occupancy
// so the top level can build a pending-register mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
`ifdef WB_PENDING_MASK_EN
  ,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  wb_entry_t        mem [DEPTH];

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  // Pointer update; a push into a full FIFO is ignored.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone decide which slots are live.
    if (push && !full) mem[wr_ptr[IDX_W-1:0]] <= push_entry;
  end

`ifdef WB_PENDING_MASK_EN
  assign entries = mem;

  // A slot is live when its distance from the read index is below the fill count.
  always_comb begin
    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] offset;
    count       = wr_ptr - rd_ptr;
    offset      = '0;
    entry_valid = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offset         = IDX_W'(j) - rd_ptr[IDX_W-1:0];
      entry_valid[j] = ({1'b0, offset} < count);
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback front end: four valid/ready producers, per-port FIFOs, round-robin
// arbitration into a single registered register-file write port.
// Optional macro WB_PENDING_MASK_EN adds the pendingMask hazard output.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] srcValid,
  output logic [NUM_SRC-1:0] srcReady,
  input  logic [ADDR_W-1:0]  srcAddr0,
  input  logic [ADDR_W-1:0]  srcAddr1,
  input  logic [ADDR_W-1:0]  srcAddr2,
  input  logic [ADDR_W-1:0]  srcAddr3,
  input  logic [DATA_W-1:0]  srcData0,
  input  logic [DATA_W-1:0]  srcData1,
  input  logic [DATA_W-1:0]  srcData2,
  input  logic [DATA_W-1:0]  srcData3,
  output logic               wbEnable,
  output logic [ADDR_W-1:0]  wbAddr,
  output logic [DATA_W-1:0]  wbData,
  output logic               busy
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [31:0]        pendingMask
`endif
);

  localparam int RR_W = $clog2(NUM_SRC);

  wb_entry_t          src_entry  [NUM_SRC];
  wb_entry_t          fifo_head  [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [RR_W-1:0]    rr_ptr;
  logic [RR_W-1:0]    grant;
  logic               grant_valid;

`ifdef WB_PENDING_MASK_EN
  wb_entry_t             fifo_entries     [NUM_SRC][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_entry_valid [NUM_SRC];
`endif

  assign src_entry[0] = '{addr: srcAddr0, data: srcData0};
  assign src_entry[1] = '{addr: srcAddr1, data: srcData1};
  assign src_entry[2] = '{addr: srcAddr2, data: srcData2};
  assign src_entry[3] = '{addr: srcAddr3, data: srcData3};

  // Ready depends only on FIFO state, never on srcValid.
  assign srcReady = ~fifo_full;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // Writes to r0 complete the handshake but are never queued.
    assign push[g] = srcValid[g] && !fifo_full[g] && (src_entry[g].addr != REG_ZERO);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[g]),
      .push_entry (src_entry[g]),
      .pop        (pop[g]),
      .full       (fifo_full[g]),
      .empty      (fifo_empty[g]),
      .head       (fifo_head[g])
`ifdef WB_PENDING_MASK_EN
      ,
      .entries    (fifo_entries[g]),
      .entry_valid(fifo_entry_valid[g])
`endif
    );
  end

  // Round-robin pick: first non-empty FIFO scanning upward from rr_ptr.
  always_comb begin
    logic [RR_W-1:0] idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant       = rr_ptr;
    idx         = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_ptr + RR_W'(k);
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  assign pop = grant_valid ? (NUM_SRC'(1) << grant) : '0;

  // Output register and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbEnable <= 1'b0;
      wbAddr   <= '0;
      wbData   <= '0;
      rr_ptr   <= '0;
    end else if (grant_valid) begin
      wbEnable <= 1'b1;
      wbAddr   <= fifo_head[grant].addr;
      wbData   <= fifo_head[grant].data;
      rr_ptr   <= grant + RR_W'(1);
    end else begin
      wbEnable <= 1'b0;
    end
  end

  assign busy = !(&fifo_empty) || wbEnable;

`ifdef WB_PENDING_MASK_EN
  // Registers with a write still queued or currently being presented.
  always_comb begin
    pendingMask = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if (fifo_entry_valid[s][e]) pendingMask[fifo_entries[s][e].addr] = 1'b1;
      end
    end
    if (wbEnable) pendingMask[wbAddr] = 1'b1;
    pendingMask[0] = 1'b0;
  end
`endif

endmodule
